umi_regbank: RTL and testbench

- Control/status register bank that sits directly downstream of the UMI-to-register bridge.
- Consumes the single-port register interface: write/read strobes, address, write data and protection bits.
- Returns read data, error and ready to the bridge in the same cycle as the access.
- Provides control outputs, sampled status inputs, rising-edge interrupt capture and a free-running cycle counter to the surrounding device.

---
 rtl/umi_regbank_if.sv | 24 ++
 rtl/umi_regbank.sv | 183 ++++++++++++++++++
 tb/tb_umi_regbank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/umi_regbank_if.sv
// Single-port register bus between the UMI-to-register bridge (master) and a register bank (slave).
interface umi_regbank_if #(
    parameter int RW  = 32,
    parameter int RAW = 32
);
    logic           reg_write;
    logic           reg_read;
    logic [RAW-1:0] reg_addr;
    logic [RW-1:0]  reg_wdata;
    logic [1:0]     reg_prot;
    logic [RW-1:0]  reg_rdata;
    logic [1:0]     reg_err;
    logic           reg_ready;

    modport master (
        output reg_write, reg_read, reg_addr, reg_wdata, reg_prot,
        input  reg_rdata, reg_err, reg_ready
    );

    modport slave (
        input  reg_write, reg_read, reg_addr, reg_wdata, reg_prot,
        output reg_rdata, reg_err, reg_ready
    );
endinterface

// File: rtl/umi_regbank.sv
// Control/status register bank behind the UMI register bridge: ID, status, W1C interrupts, cycle counter, control regs.
// Optional write-protection LOCK register at 0x14 is built when UMI_REGBANK_LOCK_EN is defined.
module umi_regbank #(
    parameter int          RW      = 32,
    parameter int          RAW     = 32,
    parameter int          NCTRL   = 4,
    parameter int          NSTAT   = 8,
    parameter logic [31:0] ID      = 32'h0,
    parameter logic [31:0] CTRLRST = 32'h0
) (
    input  logic                clk,
    input  logic                nreset,
    umi_regbank_if.slave        bus,
    input  logic [NSTAT-1:0]    status_in,
    output logic [NCTRL*RW-1:0] ctrl_out,
    output logic                irq
);
    localparam logic [5:0] IDX_ID     = 6'd0;
    localparam logic [5:0] IDX_STATUS = 6'd1;
    localparam logic [5:0] IDX_PEND   = 6'd2;
    localparam logic [5:0] IDX_EN     = 6'd3;
    localparam logic [5:0] IDX_CYCLE  = 6'd4;
    localparam logic [5:0] IDX_LOCK   = 6'd5;
    localparam int         CTRL_BASE  = 16;

    logic             acc;
    logic             wr_acc;
    logic             wr_ok;
    logic [5:0]       idx;
    logic             addr_hi_nz;
    logic             ctrl_hit;
    logic             lock_hit;
    logic             prot_fail;
    logic             decode_err;
    logic             ro_hit;
    logic [1:0]       err;
    logic [RW-1:0]    ctrl_rd;
    logic [RW-1:0]    lock_rd;
    logic [RW-1:0]    rd_value;

    logic             ready_reg;
    logic             irq_reg;
    logic [NSTAT-1:0] status_s_reg;
    logic [NSTAT-1:0] status_d_reg;
    logic [NSTAT-1:0] pend_reg;
    logic [NSTAT-1:0] pend_next;
    logic [NSTAT-1:0] en_reg;
    logic [NSTAT-1:0] rise;
    logic [NSTAT-1:0] w1c_mask;
    logic [RW-1:0]    cycle_reg;
    logic [RW-1:0]    cycle_next;

    assign acc    = (bus.reg_write | bus.reg_read) & ready_reg;
    assign wr_acc = acc & bus.reg_write;
    assign idx    = bus.reg_addr[7:2];

    generate
        if (RAW > 8) begin : g_addr_hi
            assign addr_hi_nz = |bus.reg_addr[RAW-1:8];
        end else begin : g_addr_nohi
            assign addr_hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        ctrl_hit = 1'b0;
        ctrl_rd  = '0;
        for (int i = 0; i < NCTRL; i++) begin
            if (idx == 6'(CTRL_BASE + i)) begin
                ctrl_hit = 1'b1;
                ctrl_rd  = ctrl_out[i*RW +: RW];
            end
        end
    end

`ifdef UMI_REGBANK_LOCK_EN
    logic lock_reg;
    logic unused_prot;

    assign lock_hit    = (idx == IDX_LOCK);
    assign lock_rd     = RW'(lock_reg);
    assign unused_prot = bus.reg_prot[1];
    // LOCK itself always needs privilege; once locked, CTRL and IRQ_EN need it too.
    assign prot_fail   = bus.reg_write & ~bus.reg_prot[0] &
                         (lock_hit | (lock_reg & (ctrl_hit | (idx == IDX_EN))));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lock_reg <= 1'b0;
        end else if (wr_ok && lock_hit && bus.reg_wdata[0]) begin
            lock_reg <= 1'b1;
        end
    end
`else
    logic unused_prot;

    assign lock_hit    = 1'b0;
    assign lock_rd     = '0;
    assign prot_fail   = 1'b0;
    assign unused_prot = ^bus.reg_prot;
`endif

    assign decode_err = (bus.reg_addr[1:0] != 2'b00) | addr_hi_nz |
                        ~((idx <= IDX_CYCLE) | lock_hit | ctrl_hit);
    assign ro_hit     = (idx == IDX_ID) | (idx == IDX_STATUS);

    always_comb begin
        err = 2'b00;
        if (acc) begin
            if (decode_err) begin
                err = 2'b11;
            end else if (bus.reg_write & (ro_hit | prot_fail)) begin
                err = 2'b10;
            end
        end
    end

    assign wr_ok = wr_acc & (err == 2'b00);

    always_comb begin
        rd_value = '0;
        case (idx)
            IDX_ID:     rd_value = ID[RW-1:0];
            IDX_STATUS: rd_value = RW'(status_s_reg);
            IDX_PEND:   rd_value = RW'(pend_reg);
            IDX_EN:     rd_value = RW'(en_reg);
            IDX_CYCLE:  rd_value = cycle_reg;
            IDX_LOCK:   rd_value = lock_rd;
            default:    rd_value = ctrl_rd;
        endcase
    end

    // Read data reflects pre-edge state, so a combined write+read returns the old value.
    assign bus.reg_rdata = (acc && err == 2'b00) ? rd_value : '0;
    assign bus.reg_err   = err;
    assign bus.reg_ready = ready_reg;
    assign irq           = irq_reg;

    assign rise       = status_s_reg & ~status_d_reg;
    assign w1c_mask   = (wr_ok && idx == IDX_PEND) ? bus.reg_wdata[NSTAT-1:0] : '0;
    assign pend_next  = (pend_reg & ~w1c_mask) | rise;
    assign cycle_next = (wr_ok && idx == IDX_CYCLE) ? bus.reg_wdata : cycle_reg + RW'(1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ready_reg    <= 1'b0;
            irq_reg      <= 1'b0;
            status_s_reg <= '0;
            status_d_reg <= '0;
            pend_reg     <= '0;
            en_reg       <= '0;
            cycle_reg    <= '0;
        end else begin
            ready_reg    <= ~wr_acc;
            irq_reg      <= |(pend_reg & en_reg);
            status_s_reg <= status_in;
            status_d_reg <= status_s_reg;
            pend_reg     <= pend_next;
            cycle_reg    <= cycle_next;
            if (wr_ok && idx == IDX_EN) begin
                en_reg <= bus.reg_wdata[NSTAT-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCTRL; gi++) begin : g_ctrl
            localparam logic [5:0] CIDX = 6'(CTRL_BASE + gi);
            logic [RW-1:0] ctrl_reg;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    ctrl_reg <= CTRLRST[RW-1:0];
                end else if (wr_ok && idx == CIDX) begin
                    ctrl_reg <= bus.reg_wdata;
                end
            end

            assign ctrl_out[gi*RW +: RW] = ctrl_reg;
        end
    endgenerate
endmodule

// File: tb/tb_umi_regbank.sv
// Directed scoreboard bench for umi_regbank: register map, W1C interrupts, cycle wrap, decode errors, optional LOCK.
module tb_umi_regbank;
    localparam int          RW     = 32;
    localparam int          RAW    = 32;
    localparam int          NCTRL  = 4;
    localparam int          NSTAT  = 8;
    localparam logic [31:0] ID_VAL = 32'hA5A5_0001;
    localparam logic [31:0] CRST   = 32'h0000_1234;

    logic                clk = 1'b0;
    logic                nreset = 1'b0;
    logic [NSTAT-1:0]    status_in = '0;
    logic [NCTRL*RW-1:0] ctrl_out;
    logic                irq;
    int                  total = 0;
    int                  bad = 0;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;
    exp_t sb[$];

    umi_regbank_if #(.RW(RW), .RAW(RAW)) bus ();

    umi_regbank #(
        .RW(RW), .RAW(RAW), .NCTRL(NCTRL), .NSTAT(NSTAT), .ID(ID_VAL), .CTRLRST(CRST)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus),
        .status_in(status_in),
        .ctrl_out(ctrl_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one access at a negedge once ready, checks same-cycle rdata/err, returns 1ns after the accepting edge.
    task automatic do_acc(input string tag, input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] prot, input logic chk_rd,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        exp_t e;
        exp_t got;
        int   waits;
        @(negedge clk);
        waits = 0;
        while (bus.reg_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 8) chk({tag, "_ready_timeout"}, 32'(bus.reg_ready), 32'd1);
        bus.reg_write = wr;
        bus.reg_read  = rd;
        bus.reg_addr  = addr;
        bus.reg_wdata = wdata;
        bus.reg_prot  = prot;
        e.chk_rd = chk_rd;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        $display("txn %s wr=%b rd=%b addr=%h wdata=%h prot=%b -> rdata=%h err=%b",
                 tag, wr, rd, addr, wdata, prot, bus.reg_rdata, bus.reg_err);
        if (got.chk_rd) chk({tag, "_rdata"}, bus.reg_rdata, got.rdata);
        chk({tag, "_err"}, 32'(bus.reg_err), 32'(got.err));
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        bus.reg_read  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reg_write = 1'b0;
        bus.reg_read  = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.reg_prot  = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.reg_ready), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < NCTRL; i++) chk("rst_ctrl", ctrl_out[i*RW +: RW], CRST);
        nreset = 1'b1;

        do_acc("id_read", 1'b0, 1'b1, 32'h00, 32'h0, 2'b00, 1'b1, ID_VAL, 2'b00);

        // CTRL[2] write, ready gap, readback
        do_acc("ctrl2_wr", 1'b1, 1'b0, 32'h48, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        chk("ready_low_after_wr", 32'(bus.reg_ready), 32'd0);
        chk("ctrl2_out", ctrl_out[95:64], 32'hDEAD_BEEF);
        chk("ctrl1_out_untouched", ctrl_out[63:32], CRST);
        @(negedge clk);
        chk("ready_high_again", 32'(bus.reg_ready), 32'd1);
        do_acc("ctrl2_rd", 1'b0, 1'b1, 32'h48, 32'h0, 2'b00, 1'b1, 32'hDEAD_BEEF, 2'b00);

        // Combined write+read shows the pre-write value
        do_acc("ctrl1_wr_rd", 1'b1, 1'b1, 32'h44, 32'h1111_2222, 2'b00, 1'b1, CRST, 2'b00);
        do_acc("ctrl1_rd", 1'b0, 1'b1, 32'h44, 32'h0, 2'b00, 1'b1, 32'h1111_2222, 2'b00);

        // Interrupt latency: edge on bit0 (enabled) and bit7 (not enabled)
        do_acc("en_wr", 1'b1, 1'b0, 32'h0C, 32'h1, 2'b00, 1'b0, 32'h0, 2'b00);
        do_acc("en_rd", 1'b0, 1'b1, 32'h0C, 32'h0, 2'b00, 1'b1, 32'h1, 2'b00);
        @(negedge clk);
        status_in = 8'h81;
        @(negedge clk);
        chk("irq_lat1", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lat2", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lat3", 32'(irq), 32'd1);
        do_acc("pend_rd", 1'b0, 1'b1, 32'h08, 32'h0, 2'b00, 1'b1, 32'h81, 2'b00);

        // W1C in the same cycle as a fresh rising edge: set wins
        status_in = 8'h80;
        repeat (3) @(negedge clk);
        status_in = 8'h81;
        do_acc("w1c_vs_rise", 1'b1, 1'b0, 32'h08, 32'h1, 2'b00, 1'b0, 32'h0, 2'b00);
        do_acc("pend_rd_setwins", 1'b0, 1'b1, 32'h08, 32'h0, 2'b00, 1'b1, 32'h81, 2'b00);
        chk("irq_still_high", 32'(irq), 32'd1);

        // Clean W1C: irq drops one cycle after PEND clears
        repeat (2) @(negedge clk);
        do_acc("w1c_clean", 1'b1, 1'b0, 32'h08, 32'h1, 2'b00, 1'b0, 32'h0, 2'b00);
        chk("irq_edge_of_clear", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        chk("irq_after_clear", 32'(irq), 32'd0);
        do_acc("pend_rd_cleared", 1'b0, 1'b1, 32'h08, 32'h0, 2'b00, 1'b1, 32'h80, 2'b00);

        // CYCLE wrap
        do_acc("cycle_wr", 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFE, 2'b00, 1'b0, 32'h0, 2'b00);
        do_acc("cycle_rd1", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b1, 32'hFFFF_FFFF, 2'b00);
        do_acc("cycle_rd2", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b1, 32'h0000_0000, 2'b00);

        // Decode and RO errors
        do_acc("misalign_rd", 1'b0, 1'b1, 32'h45, 32'h0, 2'b00, 1'b1, 32'h0, 2'b11);
        do_acc("hiaddr_rd", 1'b0, 1'b1, 32'h1000, 32'h0, 2'b00, 1'b1, 32'h0, 2'b11);
        do_acc("unmapped_rd", 1'b0, 1'b1, 32'h50, 32'h0, 2'b00, 1'b1, 32'h0, 2'b11);
        do_acc("status_wr", 1'b1, 1'b0, 32'h04, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0, 2'b10);
        @(negedge clk);
        chk("ready_low_after_errwr", 32'(bus.reg_ready), 32'd0);
        do_acc("status_rd", 1'b0, 1'b1, 32'h04, 32'h0, 2'b00, 1'b1, 32'h81, 2'b00);
        do_acc("id_wr", 1'b1, 1'b0, 32'h00, 32'h0, 2'b00, 1'b1, 32'h0, 2'b10);

`ifdef UMI_REGBANK_LOCK_EN
        do_acc("lock_wr_unpriv", 1'b1, 1'b0, 32'h14, 32'h1, 2'b00, 1'b1, 32'h0, 2'b10);
        do_acc("lock_rd0", 1'b0, 1'b1, 32'h14, 32'h0, 2'b00, 1'b1, 32'h0, 2'b00);
        do_acc("lock_wr_priv", 1'b1, 1'b0, 32'h14, 32'h1, 2'b01, 1'b0, 32'h0, 2'b00);
        do_acc("lock_wr_zero", 1'b1, 1'b0, 32'h14, 32'h0, 2'b01, 1'b0, 32'h0, 2'b00);
        do_acc("lock_rd1", 1'b0, 1'b1, 32'h14, 32'h0, 2'b00, 1'b1, 32'h1, 2'b00);
        do_acc("ctrl0_wr_unpriv", 1'b1, 1'b0, 32'h40, 32'h5, 2'b00, 1'b1, 32'h0, 2'b10);
        chk("ctrl0_locked_out", ctrl_out[31:0], CRST);
        do_acc("en_wr_unpriv", 1'b1, 1'b0, 32'h0C, 32'h0, 2'b00, 1'b1, 32'h0, 2'b10);
        do_acc("ctrl0_wr_priv", 1'b1, 1'b0, 32'h40, 32'h5, 2'b01, 1'b0, 32'h0, 2'b00);
        chk("ctrl0_priv_out", ctrl_out[31:0], 32'h5);
`else
        do_acc("lock_rd_unmapped", 1'b0, 1'b1, 32'h14, 32'h0, 2'b00, 1'b1, 32'h0, 2'b11);
        do_acc("lock_wr_unmapped", 1'b1, 1'b0, 32'h14, 32'h1, 2'b01, 1'b1, 32'h0, 2'b11);
        do_acc("ctrl0_wr_noprot", 1'b1, 1'b0, 32'h40, 32'h5, 2'b00, 1'b0, 32'h0, 2'b00);
        chk("ctrl0_out", ctrl_out[31:0], 32'h5);
`endif

        // Reset arriving mid-access discards the write
        @(negedge clk);
        @(negedge clk);
        bus.reg_write = 1'b1;
        bus.reg_addr  = 32'h4C;
        bus.reg_wdata = 32'h0000_CAFE;
        bus.reg_prot  = 2'b01;
        #2;
        nreset = 1'b0;
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        chk("rst_mid_ctrl3", ctrl_out[127:96], CRST);
        chk("rst_mid_ready", 32'(bus.reg_ready), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        do_acc("pend_after_rst", 1'b0, 1'b1, 32'h08, 32'h0, 2'b00, 1'b1, 32'h0, 2'b00);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
